// File: rtl/clk_div_pkg.sv
// Shared definitions for the clock divider bank.
// Holds the channel state type and divisor clamping helper.
package clk_div_pkg;

    localparam int DIV_MIN = 2;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } chan_state_t;

    // Divisors below DIV_MIN cannot produce a high and a low phase.
    function automatic logic [31:0] clamp_div(input logic [31:0] v);
        return (v < 32'(DIV_MIN)) ? 32'(DIV_MIN) : v;
    endfunction

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: glitch-free divided clock with rise strobe.
// Divisor and enable changes only land on period boundaries.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_div_wr,
    input  logic [DIV_W-1:0] i_div_data,
    input  logic             i_sync,
    output logic             o_clk,
    output logic             o_rise,
    output logic             o_pend
);

    localparam logic [DIV_W-1:0] DIV_INIT =
        DIV_W'(clamp_div(32'(DIV_RESET)));

    chan_state_t      r_state;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] r_div_act;
    logic [DIV_W-1:0] r_div_pend;
    logic             r_pend;
    logic             r_clk;
    logic             r_rise;

    chan_state_t      w_state_nx;
    logic [DIV_W-1:0] w_cnt_nx;
    logic [DIV_W-1:0] w_div_act_nx;
    logic [DIV_W-1:0] w_div_pend_nx;
    logic             w_pend_nx;
    logic             w_clk_nx;
    logic             w_rise_nx;
    logic             w_apply;
    logic             w_boundary;
    logic [DIV_W:0]   w_half_nx;
    logic [DIV_W-1:0] w_div_in;

    assign w_div_in   = DIV_W'(clamp_div(32'(i_div_data)));
    assign w_boundary = (r_cnt == (r_div_act - DIV_W'(1)));

    // Next-state, counter, divisor handoff and registered output decode.
    always_comb begin
        w_state_nx    = r_state;
        w_cnt_nx      = r_cnt;
        w_div_act_nx  = r_div_act;
        w_div_pend_nx = r_div_pend;
        w_pend_nx     = r_pend;
        w_rise_nx     = 1'b0;
        w_apply       = 1'b0;
        w_half_nx     = '0;
        w_clk_nx      = 1'b0;

        unique case (r_state)
            IDLE: begin
                // Nothing is running, so a pending divisor lands at once.
                w_apply = r_pend;
                if (i_en) begin
                    w_state_nx = RUN;
                    w_cnt_nx   = '0;
                    w_rise_nx  = 1'b1;
                end
            end
            RUN: begin
                if (i_sync && i_en) begin
                    // Phase restart wins over the boundary decision.
                    w_cnt_nx  = '0;
                    w_rise_nx = 1'b1;
                    w_apply   = r_pend;
                end else if (w_boundary) begin
                    w_cnt_nx = '0;
                    w_apply  = r_pend;
                    if (i_en) begin
                        w_rise_nx = 1'b1;
                    end else begin
                        // Low phase just ended, so parking here is runt-free.
                        w_state_nx = IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt + DIV_W'(1);
                end
            end
            default: begin
                w_state_nx = IDLE;
                w_cnt_nx   = '0;
            end
        endcase

        if (w_apply) begin
            w_div_act_nx = r_div_pend;
            w_pend_nx    = 1'b0;
        end

        // A fresh write always wins and re-arms the pending flag.
        if (i_div_wr) begin
            w_div_pend_nx = w_div_in;
            w_pend_nx     = 1'b1;
        end

        // Odd divisors give the extra cycle to the high phase.
        w_half_nx = ({1'b0, w_div_act_nx} + (DIV_W+1)'(1)) >> 1;
        w_clk_nx  = (w_state_nx == RUN) &&
                    ({1'b0, w_cnt_nx} < w_half_nx);
    end

    // Channel state register with asynchronous reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_div_act  <= DIV_INIT;
            r_div_pend <= DIV_INIT;
            r_pend     <= 1'b0;
            r_clk      <= 1'b0;
            r_rise     <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_cnt      <= w_cnt_nx;
            r_div_act  <= w_div_act_nx;
            r_div_pend <= w_div_pend_nx;
            r_pend     <= w_pend_nx;
            r_clk      <= w_clk_nx;
            r_rise     <= w_rise_nx;
        end
    end

    assign o_clk  = r_clk;
    assign o_rise = r_rise;
    assign o_pend = r_pend;

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock divider channels off the system clock.
// A shared sync pulse phase-aligns all running channels.
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int DIV_W     = 8,
    parameter int DIV_RESET = 5
) (
    input  logic                    clk_125mhz,
    input  logic                    reset,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH-1:0]       div_wr,
    input  logic [NUM_CH*DIV_W-1:0] div_data,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       clk_out,
    output logic [NUM_CH-1:0]       rise_tick,
    output logic [NUM_CH-1:0]       div_pending
);

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_chan #(
            .DIV_W     (DIV_W),
            .DIV_RESET (DIV_RESET)
        ) u_chan (
            .i_clk      (clk_125mhz),
            .i_rst      (reset),
            .i_en       (en[g]),
            .i_div_wr   (div_wr[g]),
            .i_div_data (div_data[g*DIV_W +: DIV_W]),
            .i_sync     (sync),
            .o_clk      (clk_out[g]),
            .o_rise     (rise_tick[g]),
            .o_pend     (div_pending[g])
        );
    end

endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank (2 channels, 8-bit divisors).
// Expected output vectors are queued per driven cycle and checked after the edge.
module tb_clk_div_bank;

    logic        clk_125mhz = 1'b0;
    logic        reset = 1'b0;
    logic [1:0]  en = '0;
    logic [1:0]  div_wr = '0;
    logic [15:0] div_data = '0;
    logic        sync = 1'b0;
    logic [1:0]  clk_out;
    logic [1:0]  rise_tick;
    logic [1:0]  div_pending;

    int n_chk = 0;
    int n_fail = 0;

    logic [5:0] exp_q[$];
    string      tag_q[$];

    clk_div_bank #(
        .NUM_CH    (2),
        .DIV_W     (8),
        .DIV_RESET (5)
    ) dut (
        .clk_125mhz  (clk_125mhz),
        .reset       (reset),
        .en          (en),
        .div_wr      (div_wr),
        .div_data    (div_data),
        .sync        (sync),
        .clk_out     (clk_out),
        .rise_tick   (rise_tick),
        .div_pending (div_pending)
    );

    always #5 clk_125mhz = ~clk_125mhz;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Expected {pend, rise, clk} bits of one channel at period phase ph.
    // ph < 0 means the channel is parked.
    function automatic logic [5:0] chx(input int ch, input int ph,
                                       input int d, input bit pd);
        logic [5:0] v;
        v = '0;
        v[ch]     = (ph >= 0) && (ph < (d + 1) / 2);
        v[2 + ch] = (ph == 0);
        v[4 + ch] = pd;
        return v;
    endfunction

    task automatic step(input logic [1:0] e, input logic [1:0] w,
                        input logic [15:0] d, input logic s,
                        input logic [5:0] x, input string t);
        @(negedge clk_125mhz);
        en       = e;
        div_wr   = w;
        div_data = d;
        sync     = s;
        exp_q.push_back(x);
        tag_q.push_back(t);
    endtask

    always @(posedge clk_125mhz) begin
        #1;
        if (exp_q.size() != 0) begin
            logic [5:0] e;
            string      t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            check(t, {div_pending, rise_tick, clk_out}, e);
        end
    end

    initial begin
        logic [5:0] idle1;
        idle1 = chx(1, -1, 5, 0);

        #1 reset = 1'b1;
        #1;
        check("rst_clk", clk_out, 0);
        check("rst_rise", rise_tick, 0);
        check("rst_pend", div_pending, 0);
        @(negedge clk_125mhz);
        @(negedge clk_125mhz);
        reset = 1'b0;

        step(2'b00, 2'b00, 16'd0, 1'b0, 6'd0, "idle");
        step(2'b00, 2'b00, 16'd0, 1'b0, 6'd0, "idle");

        for (int i = 0; i < 15; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i % 5, 5, 0) | idle1, "d5");

        step(2'b01, 2'b00, 16'd0, 1'b0, chx(0, 0, 5, 0) | idle1, "d5_pre");
        step(2'b01, 2'b01, 16'd4, 1'b0, chx(0, 1, 5, 1) | idle1, "wr4");
        for (int i = 2; i < 5; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i, 5, 1) | idle1, "d5_tail");
        for (int i = 0; i < 8; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i % 4, 4, 0) | idle1, "d4");

        step(2'b01, 2'b01, 16'd0, 1'b0, chx(0, 0, 4, 1) | idle1, "wr0");
        for (int i = 1; i < 4; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i, 4, 1) | idle1, "d4_tail");
        for (int i = 0; i < 6; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i % 2, 2, 0) | idle1, "d2_from0");

        step(2'b01, 2'b01, 16'd1, 1'b0, chx(0, 0, 2, 1) | idle1, "wr1");
        step(2'b01, 2'b00, 16'd0, 1'b0, chx(0, 1, 2, 1) | idle1, "wr1_wait");
        for (int i = 0; i < 6; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i % 2, 2, 0) | idle1, "d2_from1");

        step(2'b01, 2'b01, 16'd5, 1'b0, chx(0, 0, 2, 1) | idle1, "wr5");
        step(2'b01, 2'b00, 16'd0, 1'b0, chx(0, 1, 2, 1) | idle1, "wr5_wait");
        for (int i = 0; i < 6; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i % 5, 5, 0) | idle1, "d5_back");
        for (int i = 1; i < 5; i++)
            step(2'b00, 2'b00, 16'd0, 1'b0,
                 chx(0, i, 5, 0) | idle1, "dis_finish");
        for (int i = 0; i < 3; i++)
            step(2'b00, 2'b00, 16'd0, 1'b0,
                 chx(0, -1, 5, 0) | idle1, "parked");
        step(2'b01, 2'b00, 16'd0, 1'b0, chx(0, 0, 5, 0) | idle1, "reen");
        for (int i = 1; i < 5; i++)
            step(2'b01, 2'b00, 16'd0, 1'b0,
                 chx(0, i, 5, 0) | idle1, "reen_run");

        step(2'b01, 2'b10, 16'h0A00, 1'b0,
             chx(0, 0, 5, 0) | chx(1, -1, 10, 1), "wr10");
        step(2'b01, 2'b00, 16'd0, 1'b0,
             chx(0, 1, 5, 0) | chx(1, -1, 10, 0), "ch1_apply");
        step(2'b11, 2'b00, 16'd0, 1'b0,
             chx(0, 2, 5, 0) | chx(1, 0, 10, 0), "ch1_start");
        for (int i = 1; i < 4; i++)
            step(2'b11, 2'b00, 16'd0, 1'b0,
                 chx(0, (2 + i) % 5, 5, 0) | chx(1, i, 10, 0), "offset");
        step(2'b11, 2'b00, 16'd0, 1'b1,
             chx(0, 0, 5, 0) | chx(1, 0, 10, 0), "sync");
        for (int i = 1; i <= 20; i++)
            step(2'b11, 2'b00, 16'd0, 1'b0,
                 chx(0, i % 5, 5, 0) | chx(1, i % 10, 10, 0), "aligned");

        step(2'b11, 2'b01, 16'd3, 1'b0,
             chx(0, 1, 5, 1) | chx(1, 1, 10, 0), "wr3");
        @(posedge clk_125mhz);
        #2;
        check("pre_rst_clk", clk_out, 2'b11);
        reset  = 1'b1;
        en     = 2'b00;
        div_wr = 2'b00;
        #1;
        check("arst_clk", clk_out, 0);
        check("arst_rise", rise_tick, 0);
        check("arst_pend", div_pending, 0);
        @(negedge clk_125mhz);
        reset = 1'b0;

        step(2'b00, 2'b00, 16'd0, 1'b0, 6'd0, "post_rst_idle");
        for (int i = 0; i < 10; i++)
            step(2'b11, 2'b00, 16'd0, 1'b0,
                 chx(0, i % 5, 5, 0) | chx(1, i % 5, 5, 0), "rst_revert");

        @(posedge clk_125mhz);
        #2;
        check("drain", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel, runtime-programmable clock divider driven from the 125 MHz system clock. It generates the camera XCLK and auxiliary sensor/peripheral clocks. Each channel has an independent divisor, enable and rising-edge strobe. Divisor changes and enable/disable take effect only at period boundaries, so outputs never glitch. A global sync input phase-aligns all running channels.

## Interface
- NUM_CH, 2, number of independent output channels (≥1)
- DIV_W, 8, divisor width in bits (≥2)
- DIV_RESET, 5, divisor loaded into every channel at reset (5 gives 25 MHz from 125 MHz); values <2 clamp to 2

- clk_125mhz  in  1  system clock; only clock in the block
- reset  in  1  asynchronous, active-high reset
- en  in  NUM_CH  per-channel run enable, level
- div_wr  in  NUM_CH  per-channel divisor write strobe, 1 cycle
- div_data  in  NUM_CH*DIV_W  packed divisors; channel i uses bits [i*DIV_W +: DIV_W]
- sync  in  1  global phase-restart pulse
- clk_out  out  NUM_CH  divided clock outputs, registered
- rise_tick  out  NUM_CH  1-cycle pulse in the first high cycle of each clk_out period
- div_pending  out  NUM_CH  a written divisor is waiting for a period boundary

## Operation
- Per-channel state: IDLE (clk_out=0, cnt=0) and RUN.
- Per-channel registers: cnt[DIV_W], div_act, div_pend, pend flag.
- Period of D cycles in RUN; cnt runs 0..D-1. clk_out=1 while cnt < H and 0 otherwise, where H=(D+1)>>1. Odd D therefore gives the extra cycle to the high phase (D=5: 3 high, 2 low).
- Boundary = RUN cycle with cnt==div_act-1. At the next edge, cnt returns to 0.
- IDLE→RUN: en=1 in IDLE. Next edge: cnt=0, clk_out=1, rise_tick=1. If pend is set, div_act=div_pend is applied on the same edge.
- RUN→IDLE: en=0 sampled at a boundary. clk_out is already low, so there is no runt. en=0 elsewhere lets the current period finish.
- Divisor write: div_wr stores clamp(div_data,2) into div_pend and sets pend on the next edge. In IDLE it is applied on the following edge.
  - In RUN it is applied on the edge leaving the next boundary, and pend clears on that edge.
  - A write in the boundary cycle itself is applied at the following boundary.
  - A write while pend is set overwrites div_pend.
- sync=1: every RUN channel forces cnt=0, clk_out=1 and rise_tick=1 on the next edge, and applies any pending divisor. IDLE channels ignore sync.
  - If a channel is in its low phase, sync shortens that low phase (accepted; sync is for startup alignment).
  - sync has priority over the normal boundary/disable decision. A channel with en=0 restarts only if sync and en=1 coincide; otherwise it continues to its boundary.
- div_data may change freely when div_wr=0.

## Timing
- Reset (async assert, applied without a clock edge):
  - clk_out=0, rise_tick=0, div_pending=0, cnt=0, all channels IDLE.
  - div_act=clamp(DIV_RESET,2).
- en↑ to first clk_out↑ / rise_tick: 1 cycle.
- div_wr to div_pending=1: 1 cycle. div_pending falls on the edge where the new divisor starts its first period.
- Output frequency: 125 MHz / D. D=2 toggles every cycle (62.5 MHz).
- All outputs come directly from flops; there are no combinational input-to-output paths.
- Deasserting reset mid-operation restarts from the reset state. Channels with en=1 start 1 cycle after the first active edge.

## Structure
- clk_div_pkg: DIV_MIN=2 constant, state enum {IDLE, RUN}, and a clamp function for divisor values.
- Sub-module clk_div_chan (one channel, DIV_W/DIV_RESET parameters) holds all per-channel logic. clk_div_bank instantiates NUM_CH copies with a generate loop and fans out sync.

## Test plan
- Reset, then en[0]=1 with default divisor 5:
  - rise_tick[0] 1 cycle after en.
  - clk_out[0] repeats 1,1,1,0,0.
  - rise_tick every 5 cycles.
- div_wr[0] with 4 in the middle of a 5-period: div_pending=1 next cycle. The current period completes with 5 cycles, then the pattern becomes 1,1,0,0 and div_pending clears at the switch.
- div_wr with 0, and separately with 1: both clamp to 2, giving a 1,0 toggle (62.5 MHz).
- en[0]=0 during the high phase: the period completes, clk_out parks at 0 and rise_tick stops. Re-asserting en restarts 1 cycle later with clk_out=1.
- Channels at D=5 and D=10 phase-offset, then a sync pulse: both channels raise rise_tick on the same edge, and coincide every 10 cycles thereafter.
- Asynchronous reset asserted while clk_out=1: clk_out and div_pending go to 0 without a clock edge. A pending divisor is discarded and div_act reverts to DIV_RESET.
